// File: rtl/mod_inv_bgcd.sv
// mod_inv_bgcd: modular inverse x^-1 mod m by binary extended GCD, one step per cycle.
// Define MODINV_CYCLE_CNT_EN to add the `cycles` output (RUN cycles of the last operation).
module mod_inv_bgcd #(
  parameter int NBITS = 2048,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_p,
  input  logic [NBITS-1:0] x,
  input  logic [NBITS-1:0] m,
  output logic             busy,
  output logic             done_p,
  output logic [NBITS-1:0] inv,
  output logic [1:0]       err
`ifdef MODINV_CYCLE_CNT_EN
  ,
  output logic [CNTW-1:0]  cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [NBITS-1:0] ONE   = NBITS'(1);
  localparam logic [NBITS-1:0] THREE = NBITS'(3);

  state_t           st, st_n;
  logic [NBITS-1:0] mr, mr_n;
  logic [NBITS-1:0] u, u_n;
  logic [NBITS-1:0] v, v_n;
  logic [NBITS-1:0] x1, x1_n;
  logic [NBITS-1:0] x2, x2_n;
  logic [NBITS-1:0] inv_q, inv_n;
  logic [1:0]       err_q, err_n;
`ifdef MODINV_CYCLE_CNT_EN
  logic [CNTW-1:0]  cnt, cnt_n;
  logic [CNTW-1:0]  cyc_q, cyc_n;
  logic [CNTW-1:0]  cnt_inc;
`endif

  // a/2 mod md for odd md; the a+md sum needs one extra bit
  function automatic logic [NBITS-1:0] halve(
    input logic [NBITS-1:0] a,
    input logic [NBITS-1:0] md
  );
    logic [NBITS:0] s;
    s = {1'b0, a} + (a[0] ? {1'b0, md} : '0);
    return NBITS'(s >> 1);
  endfunction

  // (a-b) mod md with a, b already in [0, md-1]
  function automatic logic [NBITS-1:0] sub_mod(
    input logic [NBITS-1:0] a,
    input logic [NBITS-1:0] b,
    input logic [NBITS-1:0] md
  );
    logic [NBITS:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[NBITS]) d = d + {1'b0, md};
    return d[NBITS-1:0];
  endfunction

  // next-state and datapath: operand checks, then one gcd step per RUN cycle
  always_comb begin
    st_n  = st;
    mr_n  = mr;
    u_n   = u;
    v_n   = v;
    x1_n  = x1;
    x2_n  = x2;
    inv_n = inv_q;
    err_n = err_q;
`ifdef MODINV_CYCLE_CNT_EN
    cnt_inc = (cnt == '1) ? cnt : cnt + CNTW'(1);
    cnt_n   = cnt;
    cyc_n   = cyc_q;
`endif
    unique case (st)
      S_IDLE: begin
        if (start_p) begin
          u_n  = x;
          mr_n = m;
          st_n = S_INIT;
        end
      end
      S_INIT: begin
        if (!mr[0] || mr < THREE) begin
          err_n = 2'b01;
          inv_n = '0;
          st_n  = S_DONE;
        end else if (u == '0 || u >= mr) begin
          err_n = 2'b10;
          inv_n = '0;
          st_n  = S_DONE;
        end else begin
          v_n  = mr;
          x1_n = ONE;
          x2_n = '0;
          st_n = S_RUN;
`ifdef MODINV_CYCLE_CNT_EN
          cnt_n = '0;
`endif
        end
      end
      S_RUN: begin
`ifdef MODINV_CYCLE_CNT_EN
        cnt_n = cnt_inc;
`endif
        if (u == ONE) begin
          inv_n = x1;
          err_n = 2'b00;
          st_n  = S_DONE;
        end else if (v == ONE) begin
          inv_n = x2;
          err_n = 2'b00;
          st_n  = S_DONE;
        end else if (u == '0 || v == '0) begin
          inv_n = '0;
          err_n = 2'b11;
          st_n  = S_DONE;
        end else if (!u[0]) begin
          u_n  = u >> 1;
          x1_n = halve(x1, mr);
        end else if (!v[0]) begin
          v_n  = v >> 1;
          x2_n = halve(x2, mr);
        end else if (u >= v) begin
          u_n  = u - v;
          x1_n = sub_mod(x1, x2, mr);
        end else begin
          v_n  = v - u;
          x2_n = sub_mod(x2, x1, mr);
        end
      end
      S_DONE: st_n = S_IDLE;
      default: st_n = S_IDLE;
    endcase
`ifdef MODINV_CYCLE_CNT_EN
    if (st_n == S_DONE) cyc_n = (st == S_RUN) ? cnt_inc : '0;
`endif
  end

  // state and datapath registers, synchronous reset clears everything
  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= S_IDLE;
      mr    <= '0;
      u     <= '0;
      v     <= '0;
      x1    <= '0;
      x2    <= '0;
      inv_q <= '0;
      err_q <= 2'b00;
`ifdef MODINV_CYCLE_CNT_EN
      cnt   <= '0;
      cyc_q <= '0;
`endif
    end else begin
      st    <= st_n;
      mr    <= mr_n;
      u     <= u_n;
      v     <= v_n;
      x1    <= x1_n;
      x2    <= x2_n;
      inv_q <= inv_n;
      err_q <= err_n;
`ifdef MODINV_CYCLE_CNT_EN
      cnt   <= cnt_n;
      cyc_q <= cyc_n;
`endif
    end
  end

  assign busy   = (st == S_INIT) || (st == S_RUN);
  assign done_p = (st == S_DONE);
  assign inv    = inv_q;
  assign err    = err_q;
`ifdef MODINV_CYCLE_CNT_EN
  assign cycles = cyc_q;
`endif

endmodule

// File: tb/tb_mod_inv_bgcd.sv
// tb_mod_inv_bgcd: directed and random checks of mod_inv_bgcd.
// Reference is extended Euclid on wide signed integers.
module tb_mod_inv_bgcd;

  localparam int N    = 64;
  localparam int NB   = 2048;
  localparam int CW   = 16;
  localparam int LMAX = 4*N+7;
  localparam int BMAX = 4*NB+7;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_p;
  logic [N-1:0]  x, m;
  logic          busy, done_p;
  logic [N-1:0]  inv;
  logic [1:0]    err;
  logic          bstart;
  logic [NB-1:0] bx, bm;
  logic          bbusy, bdone;
  logic [NB-1:0] binv;
  logic [1:0]    berr;
`ifdef MODINV_CYCLE_CNT_EN
  logic [CW-1:0] cycles, bcycles;
`endif

  always #5 clk = ~clk;

  mod_inv_bgcd #(.NBITS(N), .CNTW(CW)) dut (
    .clk(clk), .rst(rst), .start_p(start_p), .x(x), .m(m),
    .busy(busy), .done_p(done_p), .inv(inv), .err(err)
`ifdef MODINV_CYCLE_CNT_EN
    , .cycles(cycles)
`endif
  );

  mod_inv_bgcd #(.NBITS(NB), .CNTW(CW)) dut_big (
    .clk(clk), .rst(rst), .start_p(bstart), .x(bx), .m(bm),
    .busy(bbusy), .done_p(bdone), .inv(binv), .err(berr)
`ifdef MODINV_CYCLE_CNT_EN
    , .cycles(bcycles)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_done = 0;

  always @(posedge clk) if (done_p === 1'b1) n_done++;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic void ref_inv(input logic [N-1:0] xi, input logic [N-1:0] mi,
                                  output logic [N-1:0] ri, output logic [1:0] ei);
    logic signed [129:0] r0, r1, t0, t1, q, tmp;
    ri = '0;
    if (!mi[0] || mi < 64'd3) begin
      ei = 2'b01;
    end else if (xi == '0 || xi >= mi) begin
      ei = 2'b10;
    end else begin
      r0 = {66'd0, mi}; r1 = {66'd0, xi};
      t0 = '0; t1 = 130'sd1;
      while (r1 != 0) begin
        q = r0 / r1;
        tmp = r0 - q*r1; r0 = r1; r1 = tmp;
        tmp = t0 - q*t1; t0 = t1; t1 = tmp;
      end
      if (r0 != 1) begin
        ei = 2'b11;
      end else begin
        if (t0 < 0) t0 = t0 + {66'd0, mi};
        ri = t0[N-1:0];
        ei = 2'b00;
      end
    end
  endfunction

`ifdef MODINV_CYCLE_CNT_EN
  function automatic int ref_steps(input logic [N-1:0] xi, input logic [N-1:0] mi);
    logic [N-1:0] a, b;
    int n;
    a = xi; b = mi; n = 1;
    while (!(a == 1 || b == 1 || a == 0 || b == 0)) begin
      if (!a[0]) a = a >> 1;
      else if (!b[0]) b = b >> 1;
      else if (a >= b) a = a - b;
      else b = b - a;
      n++;
    end
    return n;
  endfunction
`endif

  // called at a negedge; returns at the negedge of the idle cycle after done
  task automatic run_op(input logic [N-1:0] xi, input logic [N-1:0] mi,
                        output logic [N-1:0] ri, output logic [1:0] ei,
                        output logic [CW-1:0] ci);
    bit bz_bad;
    int lat;
    start_p = 1'b1; x = xi; m = mi;
    @(negedge clk);
    start_p = 1'b0;
    lat = 1; bz_bad = 0;
    while (done_p !== 1'b1 && lat <= LMAX + 10) begin
      if (busy !== 1'b1) bz_bad = 1;
      @(negedge clk);
      lat++;
    end
    chk("done_seen", done_p, 1);
    chk("busy_run", bz_bad, 0);
    chk("busy_at_done", busy, 0);
    chk("latency", lat <= LMAX, 1);
    ri = inv; ei = err;
`ifdef MODINV_CYCLE_CNT_EN
    ci = cycles;
`else
    ci = '0;
`endif
    @(negedge clk);
    chk("done_width", done_p, 0);
    chk("busy_idle", busy, 0);
  endtask

  typedef struct {
    logic [N-1:0] xv, mv, iv;
    logic [1:0]   ev;
  } vec_t;

  vec_t dv[8];
  logic [N-1:0]  xi, mi, ri, er, kk, g;
  logic [1:0]    ei, ee;
  logic [CW-1:0] ci;
  logic [127:0]  pr;
  logic [NB-1:0] bexp;
  int d0, k;

  initial begin
    dv[0] = '{64'd3, 64'd7, 64'd5, 2'b00};
    dv[1] = '{64'd6, 64'd9, 64'd0, 2'b11};
    dv[2] = '{64'd3, 64'd8, 64'd0, 2'b01};
    dv[3] = '{64'd0, 64'd7, 64'd0, 2'b10};
    dv[4] = '{64'd9, 64'd7, 64'd0, 2'b10};
    dv[5] = '{64'd1, 64'd65535, 64'd1, 2'b00};
    dv[6] = '{64'd5, 64'd1, 64'd0, 2'b01};
    dv[7] = '{64'd7, 64'd7, 64'd0, 2'b10};

    rst = 1'b1; start_p = 1'b0; x = '0; m = '0;
    bstart = 1'b0; bx = '0; bm = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_p, 0);
    chk("rst_inv", inv, 0);
    chk("rst_err", err, 0);
    chk("rst_big_busy", bbusy, 0);
    chk("rst_big_inv_zero", binv == '0, 1);
`ifdef MODINV_CYCLE_CNT_EN
    chk("rst_cycles", cycles, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op(dv[i].xv, dv[i].mv, ri, ei, ci);
      chk($sformatf("dir%0d_inv", i), ri, dv[i].iv);
      chk($sformatf("dir%0d_err", i), ei, dv[i].ev);
    end

    // reset five cycles into RUN
    start_p = 1'b1; x = 64'd12345; m = 64'd65521;
    @(negedge clk);
    start_p = 1'b0;
    repeat (6) @(negedge clk);
    chk("busy_before_rst", busy, 1);
    d0 = n_done;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done_p, 0);
    chk("mid_rst_inv", inv, 0);
    chk("mid_rst_err", err, 0);
`ifdef MODINV_CYCLE_CNT_EN
    chk("mid_rst_cycles", cycles, 0);
`endif
    repeat (300) @(negedge clk);
    chk("no_done_after_rst", n_done - d0, 0);
    run_op(64'd3, 64'd7, ri, ei, ci);
    chk("after_rst_inv", ri, 5);
    chk("after_rst_err", ei, 0);

    // start held through INIT, RUN and DONE: all ignored
    d0 = n_done;
    start_p = 1'b1; x = 64'd1; m = 64'd65535;
    @(negedge clk);
    x = 64'd3; m = 64'd7;
    repeat (3) @(negedge clk);
    start_p = 1'b0;
    repeat (40) @(negedge clk);
    chk("held_start_single_done", n_done - d0, 1);
    chk("held_start_inv", inv, 1);
    chk("held_start_err", err, 0);
    chk("held_start_busy", busy, 0);

    // start pulsed mid-RUN of a longer operation
    ref_inv(64'd12345, 64'd65521, er, ee);
    d0 = n_done;
    start_p = 1'b1; x = 64'd12345; m = 64'd65521;
    @(negedge clk);
    start_p = 1'b0;
    repeat (3) @(negedge clk);
    start_p = 1'b1; x = 64'd3; m = 64'd7;
    @(negedge clk);
    start_p = 1'b0;
    k = 0;
    while (done_p !== 1'b1 && k < LMAX) begin
      @(negedge clk);
      k++;
    end
    chk("midrun_done_seen", done_p, 1);
    chk("midrun_inv", inv, er);
    chk("midrun_err", err, ee);
    repeat (40) @(negedge clk);
    chk("midrun_single_done", n_done - d0, 1);

    // wide instance: m = 2^2048-1, x = 2
    bexp = '0; bexp[NB-1] = 1'b1;
    bstart = 1'b1; bx = '0; bx[1] = 1'b1; bm = '1;
    @(negedge clk);
    bstart = 1'b0;
    k = 1;
    while (bdone !== 1'b1 && k <= BMAX + 10) begin
      @(negedge clk);
      k++;
    end
    chk("big_done_seen", bdone, 1);
    chk("big_latency", k <= BMAX, 1);
    chk("big_inv", binv == bexp, 1);
    chk("big_err", berr, 0);
`ifdef MODINV_CYCLE_CNT_EN
    chk("big_cycles", bcycles, 2);
`endif
    @(negedge clk);

    // random 64-bit operands
    for (int i = 0; i < 400; i++) begin
      if (i % 4 == 3) begin
        g  = 64'(3 + 2*$urandom_range(0, 6));
        kk = ({$urandom, $urandom} >> 8) | 64'd1;
        mi = kk * g;
        xi = g * ({$urandom, $urandom} % kk);
        if (xi == '0) xi = g;
      end else begin
        mi = {$urandom, $urandom} | 64'd1;
        if (mi < 64'd3) mi = 64'd3;
        xi = {$urandom, $urandom} % mi;
        if (xi == '0) xi = 64'd1;
      end
      ref_inv(xi, mi, er, ee);
      run_op(xi, mi, ri, ei, ci);
      chk($sformatf("rnd%0d_err", i), ei, ee);
      chk($sformatf("rnd%0d_inv", i), ri, er);
      if (ee == 2'b00) begin
        pr = ({64'd0, ri} * {64'd0, xi}) % {64'd0, mi};
        chk($sformatf("rnd%0d_prod", i), pr, 1);
      end
`ifdef MODINV_CYCLE_CNT_EN
      if (ee == 2'b00 || ee == 2'b11)
        chk($sformatf("rnd%0d_cycles", i), ci, ref_steps(xi, mi));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
